// File: rtl/lsu_axi_bridge.sv
// Single-outstanding AXI4 data master between the memory-access stage and the bus.
// One load or store at a time; returns right-aligned load data or store completion.
//
// state | meaning
// IDLE  | ready for a request
// AR    | read address presented, waiting for ARREADY
// R     | waiting for the read beat
// WR    | AW and W presented, each dropping on its own handshake
// B     | waiting for the write response
// RSP   | one-cycle completion pulse to the requester
module lsu_axi_bridge #(
  parameter logic [3:0] AXI_ID = 4'h1,
  parameter int         ADDR_W = 64,
  parameter int         DATA_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [3:0]          req_wlen,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [3:0]          ARID,
  output logic [ADDR_W-1:0]   ARADDR,
  output logic [7:0]          ARLEN,
  output logic [2:0]          ARSIZE,
  output logic [1:0]          ARBURST,
  output logic                ARVALID,
  input  logic                ARREADY,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RLAST,
  input  logic                RVALID,
  output logic                RREADY,
  output logic [3:0]          AWID,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic [7:0]          AWLEN,
  output logic [2:0]          AWSIZE,
  output logic [1:0]          AWBURST,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WLAST,
  output logic                WVALID,
  input  logic                WREADY,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_WR, S_B, S_RSP} state_t;

  state_t                state, state_nxt;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [3:0]            wlen_q;
  logic                  aw_done, w_done;
  logic [DATA_W-1:0]     rdata_q;
  logic                  err_q;
  logic                  req_acc, req_bad, aw_ok, w_ok;
  logic [2:0]            size_q;
  logic [DATA_W/8-1:0]   strb_base;
  logic [DATA_W-1:0]     r_shift, load_data;
  logic                  unused_rlast;

  assign unused_rlast = RLAST;
  assign req_acc      = req_valid & req_ready;
  assign aw_ok        = aw_done | (AWVALID & AWREADY);
  assign w_ok         = w_done  | (WVALID & WREADY);

  // Size must be legal and the address naturally aligned to it.
  always_comb begin
    req_bad = 1'b0;
    case (req_wlen)
      4'd1:    req_bad = 1'b0;
      4'd2:    req_bad = req_addr[0];
      4'd4:    req_bad = |req_addr[1:0];
      4'd8:    req_bad = |req_addr[2:0];
      default: req_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (req_acc) state_nxt = req_bad ? S_RSP : (req_wen ? S_WR : S_AR);
      S_AR:    if (ARREADY) state_nxt = S_R;
      S_R:     if (RVALID) state_nxt = S_RSP;
      S_WR:    if (aw_ok && w_ok) state_nxt = S_B;
      S_B:     if (BVALID) state_nxt = S_RSP;
      S_RSP:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    ARVALID   = 1'b0;
    RREADY    = 1'b0;
    AWVALID   = 1'b0;
    WVALID    = 1'b0;
    BREADY    = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      S_IDLE:  req_ready = 1'b1;
      S_AR:    ARVALID   = 1'b1;
      S_R:     RREADY    = 1'b1;
      S_WR: begin
        AWVALID = ~aw_done;
        WVALID  = ~w_done;
      end
      S_B:     BREADY    = 1'b1;
      S_RSP:   rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wlen_q  <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (req_acc) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wlen_q  <= req_wlen;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        rdata_q <= '0;
        err_q   <= req_bad;
      end
      if (state == S_WR) begin
        if (AWVALID && AWREADY) aw_done <= 1'b1;
        if (WVALID && WREADY)   w_done  <= 1'b1;
      end
      if (state == S_R && RVALID) begin
        rdata_q <= load_data;
        err_q   <= |RRESP;
      end
      if (state == S_B && BVALID) err_q <= |BRESP;
    end
  end

  assign r_shift = RDATA >> {addr_q[2:0], 3'b000};

  always_comb begin
    load_data = r_shift;
    size_q    = 3'd0;
    strb_base = '0;
    case (wlen_q)
      4'd1: begin load_data = {{(DATA_W-8){1'b0}},  r_shift[7:0]};  size_q = 3'd0; strb_base = 8'h01; end
      4'd2: begin load_data = {{(DATA_W-16){1'b0}}, r_shift[15:0]}; size_q = 3'd1; strb_base = 8'h03; end
      4'd4: begin load_data = {{(DATA_W-32){1'b0}}, r_shift[31:0]}; size_q = 3'd2; strb_base = 8'h0F; end
      4'd8: begin load_data = r_shift;                              size_q = 3'd3; strb_base = 8'hFF; end
      default: ;
    endcase
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  assign ARID    = AXI_ID;
  assign ARADDR  = addr_q;
  assign ARLEN   = 8'd0;
  assign ARSIZE  = size_q;
  assign ARBURST = 2'b01;

  assign AWID    = AXI_ID;
  assign AWADDR  = addr_q;
  assign AWLEN   = 8'd0;
  assign AWSIZE  = size_q;
  assign AWBURST = 2'b01;

  assign WDATA   = wdata_q << {addr_q[2:0], 3'b000};
  assign WSTRB   = strb_base << addr_q[2:0];
  assign WLAST   = 1'b1;

endmodule

// File: doc/lsu_axi_bridge.md
Name: lsu_axi_bridge

Overview:
- Data-side AXI4 master for the pipelined RV64 core.
- Sits directly downstream of the memory-access stage and replaces its direct mm_addr/mm_wdata/mm_wlen/mm_wen/mm_ren memory port.
- Converts one load or store request at a time into AXI4 AR/R or AW/W/B transactions.
- Returns aligned read data or write completion, and flags errors, to the memory-access stage.

Parameters:
- AXI_ID, 4'h1: value driven on ARID and AWID.
- ADDR_W, 64: address width.
- DATA_W, 64: data bus width. Fixed at 64; other values are unsupported.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  access request from the memory-access stage.
- req_ready  out  1  bridge can accept a request.
- req_wen  in  1  1 = store, 0 = load.
- req_addr  in  64  byte address.
- req_wdata  in  64  store data, right-aligned.
- req_wlen  in  4  access size in bytes: 1, 2, 4 or 8.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  64  load data, right-aligned, zero-extended.
- rsp_err  out  1  bus error or illegal request.
- ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  out  4/64/8/3/2/1  read address channel.
- ARREADY  in  1
- RDATA/RRESP/RLAST/RVALID  in  64/2/1/1  read data channel.
- RREADY  out  1
- AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  out  4/64/8/3/2/1  write address channel.
- AWREADY  in  1
- WDATA/WSTRB/WLAST/WVALID  out  64/8/1/1  write data channel.
- WREADY  in  1
- BRESP/BVALID  in  2/1  write response channel.
- BREADY  out  1

Behaviour:
- FSM states: IDLE, AR, R, WR, B, RSP.
- req_ready = 1 only in IDLE. A request is accepted when req_valid && req_ready; addr, wdata, wlen and wen are registered on acceptance.
- Illegal request, checked at acceptance:
  - wlen not in {1,2,4,8}, or addr not naturally aligned (addr mod wlen != 0).
  - Goes to RSP with rsp_err=1 and rsp_rdata=0. No AXI traffic is issued.
- Load path:
  - IDLE -> AR. ARVALID=1 from the cycle after acceptance; ARVALID and ARADDR are held stable until ARREADY.
  - AR -> R on the AR handshake. RREADY=1 only in R.
  - R -> RSP on the RVALID handshake. Capture rsp_rdata = RDATA >> (8*addr[2:0]), masked to wlen bytes. Capture rsp_err = (RRESP != 2'b00).
- Store path:
  - IDLE -> WR. AWVALID and WVALID both rise the cycle after acceptance.
  - Each channel drops independently on its own handshake. AW-before-W, W-before-AW and simultaneous handshakes are all legal.
  - WR -> B once both the AW and W handshakes have completed. BREADY=1 only in B.
  - B -> RSP on the BVALID handshake. rsp_err = (BRESP != 2'b00). rsp_rdata = 0.
- RSP: rsp_valid=1 for exactly one cycle, then -> IDLE. There is no response backpressure; the memory-access stage stalls on !rsp_valid.
- Minimum latency, acceptance to rsp_valid:
  - Load: 3 cycles, with ARREADY and RVALID asserted immediately.
  - Store: 3 cycles.
  - Illegal request: 1 cycle.
- Field encoding:
  - ARSIZE/AWSIZE = log2(wlen). ARLEN/AWLEN = 0. ARBURST/AWBURST = 2'b01. WLAST = 1.
  - ARADDR/AWADDR = the registered addr, unmodified.
  - WSTRB = ((1<<wlen)-1) << addr[2:0].
  - WDATA = wdata << (8*addr[2:0]).
- RLAST is ignored, because only single beats are issued. An RVALID/BVALID seen outside R/B is not consumed (RREADY/BREADY = 0).
- Reset values: req_ready=1 (IDLE); all VALID and READY outputs 0; rsp_valid=0; rsp_err=0; rsp_rdata=0; addresses and data 0; ARID/AWID=AXI_ID.
- Reset mid-transaction: the FSM returns to IDLE on the next edge, and all AXI valids and readies are deasserted. The outstanding beat is abandoned, and the slave must be reset together with the bridge.
- A req_valid that arrives while the bridge is busy is ignored until req_ready=1. The requester holds it.

Test Plan:
- Load, wlen=8, addr 0x80000008. ARREADY is delayed 2 cycles, then RDATA=0x1122334455667788, RRESP=0. Required: ARADDR=0x80000008, ARSIZE=3, ARVALID held 3 cycles; rsp_rdata=0x1122334455667788, rsp_err=0, rsp_valid pulses the cycle after the R handshake.
- Load, wlen=4, addr 0x80000004, RDATA=0xAABBCCDD11223344. Required: ARSIZE=2, rsp_rdata=0x00000000AABBCCDD.
- Store, wlen=2, addr 0x80000006, wdata=0xBEEF. AWREADY=1 immediately, WREADY after 2 cycles, BRESP=0. Required: AWVALID drops after 1 cycle; WSTRB=0xC0; WDATA=0xBEEF000000000000; WLAST=1; rsp_valid with rsp_err=0 after B.
- Illegal requests: wlen=4 at addr 0x80000006, then wlen=3. Required: no ARVALID/AWVALID ever; rsp_valid=1 with rsp_err=1 one cycle after each acceptance.
- Error responses: RRESP=2'b10 on a load, then BRESP=2'b11 on a store. Required: rsp_err=1 on both responses; req_ready returns to 1 the cycle after each rsp_valid.
- Reset mid-transaction: assert rst for 1 cycle while in R with RVALID=0. Required: RREADY=0, ARVALID=0, rsp_valid=0 and req_ready=1 on the next edge; a fresh load then completes normally.
